// File: rtl/teclado_pkg.sv
// Shared types for the 4x4 keypad reader: FSM state encoding, key-code
// width and the column-priority helper used when a press is first seen.
package teclado_pkg;

  localparam int COD_W = 4;

  typedef enum logic [1:0] {
    VARRE       = 2'd0,
    CONFIRMA    = 2'd1,
    PRESSIONADA = 2'd2,
    SOLTA       = 2'd3
  } estado_t;

  // Index of the lowest-numbered column that is pulled low (active-low input).
  // Callers only use the result when at least one column is low.
  function automatic logic [1:0] menor_coluna(input logic [3:0] col_n);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!col_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs. Resets to RESET_VAL
// so that idle (pulled-high) keypad columns read as released after reset.
module sincronizador_2ff #(
  parameter int          W         = 4,
  parameter logic [W-1:0] RESET_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sinc_q;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sinc_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sinc_q <= meta_q;
    end
  end

  assign q = sinc_q;

endmodule

// File: rtl/leitor_teclado.sv
// 4x4 matrix keypad scanner with debounce on both press and release.
// Rows are driven one-cold; a key is reported once as row*4+column.
// Optional build macro AUTO_REPEAT_EN: while a key is held, Valido
// re-pulses every REPEAT_SAMPLES samples with the same Codigo.
module leitor_teclado
  import teclado_pkg::*;
#(
  parameter int DIV_SCAN       = 4,
  parameter int DEBOUNCE       = 3,
  parameter int REPEAT_SAMPLES = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       Colunas,
  output logic [3:0]       Linhas,
  output logic [COD_W-1:0] Codigo,
  output logic             Valido,
  output logic             Pressionada
);

  localparam logic [7:0] PRESC_MAX = 8'(DIV_SCAN - 1);
  localparam logic [3:0] DEB_LIM   = 4'(DEBOUNCE);

  // Reject out-of-range parameters at elaboration time.
  if (DIV_SCAN < 2 || DIV_SCAN > 255 || DEBOUNCE < 1 || DEBOUNCE > 15 ||
      REPEAT_SAMPLES < 1) begin : g_param_invalido
    $error("leitor_teclado: parameter out of range");
  end

  logic [3:0]       col_s;

  estado_t          estado_q, estado_d;
  logic [7:0]       presc_q, presc_d;
  logic [1:0]       linha_q, linha_d;
  logic [1:0]       coluna_q, coluna_d;
  logic [3:0]       cont_q, cont_d;
  logic [COD_W-1:0] codigo_q, codigo_d;
  logic             valido_q, valido_d;
  logic             press_q, press_d;
`ifdef AUTO_REPEAT_EN
  localparam logic [15:0] REP_MAX = 16'(REPEAT_SAMPLES - 1);
  logic [15:0]      rep_q, rep_d;
`endif

  logic             amostra;
  logic             col_baixa;
  logic [3:0]       cont_inc;

  sincronizador_2ff #(
    .W         (4),
    .RESET_VAL (4'b1111)
  ) u_sinc (
    .clk (Clock),
    .rst (Reset),
    .d   (Colunas),
    .q   (col_s)
  );

  assign amostra   = (presc_q == PRESC_MAX);
  assign col_baixa = ~col_s[coluna_q];
  // Debounce counter saturates instead of wrapping.
  assign cont_inc  = (cont_q == 4'hF) ? cont_q : cont_q + 4'd1;

  // Next-state logic: prescaler, row scan and press/release debounce FSM.
  always_comb begin
    estado_d = estado_q;
    presc_d  = amostra ? 8'd0 : presc_q + 8'd1;
    linha_d  = linha_q;
    coluna_d = coluna_q;
    cont_d   = cont_q;
    codigo_d = codigo_q;
    valido_d = 1'b0;
    press_d  = press_q;
`ifdef AUTO_REPEAT_EN
    rep_d    = rep_q;
`endif

    if (amostra) begin
      case (estado_q)
        VARRE: begin
          if (col_s != 4'b1111) begin
            // Freeze on this row; remember which column to watch.
            coluna_d = menor_coluna(col_s);
            cont_d   = 4'd0;
            estado_d = CONFIRMA;
          end else begin
            linha_d = linha_q + 2'd1;
          end
        end
        CONFIRMA: begin
          if (col_baixa) begin
            if (cont_inc >= DEB_LIM) begin
              codigo_d = {linha_q, coluna_q};
              valido_d = 1'b1;
              press_d  = 1'b1;
              cont_d   = 4'd0;
              estado_d = PRESSIONADA;
`ifdef AUTO_REPEAT_EN
              rep_d    = 16'd0;
`endif
            end else begin
              cont_d = cont_inc;
            end
          end else begin
            // Bounce or too-short press: discard and keep scanning.
            estado_d = VARRE;
            linha_d  = linha_q + 2'd1;
          end
        end
        PRESSIONADA: begin
          if (!col_baixa) begin
            cont_d   = 4'd0;
            estado_d = SOLTA;
          end else begin
`ifdef AUTO_REPEAT_EN
            if (rep_q >= REP_MAX) begin
              rep_d    = 16'd0;
              valido_d = 1'b1;
            end else begin
              rep_d = rep_q + 16'd1;
            end
`endif
          end
        end
        SOLTA: begin
          if (!col_baixa) begin
            if (cont_inc >= DEB_LIM) begin
              press_d  = 1'b0;
              cont_d   = 4'd0;
              estado_d = VARRE;
              linha_d  = linha_q + 2'd1;
            end else begin
              cont_d = cont_inc;
            end
          end else begin
            // Release glitch: key still held, no new report.
            cont_d   = 4'd0;
            estado_d = PRESSIONADA;
`ifdef AUTO_REPEAT_EN
            rep_d    = 16'd0;
`endif
          end
        end
        default: estado_d = VARRE;
      endcase
    end
  end

  // State and registered outputs; reset aborts any press in progress.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado_q <= VARRE;
      presc_q  <= 8'd0;
      linha_q  <= 2'd0;
      coluna_q <= 2'd0;
      cont_q   <= 4'd0;
      codigo_q <= '0;
      valido_q <= 1'b0;
      press_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q    <= 16'd0;
`endif
    end else begin
      estado_q <= estado_d;
      presc_q  <= presc_d;
      linha_q  <= linha_d;
      coluna_q <= coluna_d;
      cont_q   <= cont_d;
      codigo_q <= codigo_d;
      valido_q <= valido_d;
      press_q  <= press_d;
`ifdef AUTO_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  assign Linhas      = ~(4'b0001 << linha_q);
  assign Codigo      = codigo_q;
  assign Valido      = valido_q;
  assign Pressionada = press_q;

endmodule

// File: doc/leitor_teclado.md
LEITOR_TECLADO -- requirements
Module: leitor_teclado

Interface
REQ-001 SHALL have parameter DIV_SCAN, default 4, Clock cycles each row is driven before its columns are sampled (legal 2..255).
REQ-002 SHALL have parameter DEBOUNCE, default 3, consecutive matching samples needed to accept a press or a release (legal 1..15).
REQ-003 SHALL have parameter REPEAT_SAMPLES, default 64, samples between auto-repeat pulses (used only under REQ-025).
REQ-004 SHALL have port Clock, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port Reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port Colunas, input, 4 bits, keypad columns, active-low, pulled high externally, asynchronous to Clock.
REQ-007 SHALL have port Linhas, output, 4 bits, row drive, active-low one-cold.
REQ-008 SHALL have port Codigo, output, 4 bits, last accepted key code = row*4 + column.
REQ-009 SHALL have port Valido, output, 1 bit, one-cycle pulse when Codigo is updated.
REQ-010 SHALL have port Pressionada, output, 1 bit, high while an accepted key is held.

Function
REQ-011 SHALL pass Colunas through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-012 SHALL run a prescaler 0..DIV_SCAN-1; a "sample" is the cycle where prescaler = DIV_SCAN-1.
REQ-013 SHALL drive Linhas = all ones except bit[row] low; row advances 0->1->2->3->0 at each sample, but only in state VARRE.
REQ-014 SHALL implement FSM states VARRE, CONFIRMA, PRESSIONADA, SOLTA.
REQ-015 VARRE: at a sample with any synchronized column low, SHALL latch row and the lowest-index low column, clear the debounce counter, freeze row and go to CONFIRMA.
REQ-016 CONFIRMA: at each sample with the latched column still low, SHALL increment the counter; on reaching DEBOUNCE it SHALL load Codigo, pulse Valido for exactly one cycle and go to PRESSIONADA.
REQ-017 CONFIRMA: at a sample with the latched column high, SHALL return to VARRE and advance the row.
REQ-018 PRESSIONADA: Pressionada SHALL be 1; at a sample with the latched column high, SHALL clear the counter and go to SOLTA.
REQ-019 SOLTA: Pressionada SHALL stay 1; DEBOUNCE consecutive high samples SHALL go to VARRE with Pressionada = 0 and the row advanced; a low sample SHALL return to PRESSIONADA with no new Valido.
REQ-020 SHALL ignore other keys, including other columns of the frozen row, while not in VARRE.
REQ-021 Codigo SHALL hold its value between Valido pulses; the first press after a press-to-Valido path has latency <= (4+DEBOUNCE)*DIV_SCAN + 3 cycles.
REQ-022 Counters SHALL saturate and never wrap; the row index SHALL wrap 3->0.

Reset
REQ-023 While Reset = 1, regardless of Clock: state VARRE, row 0 (Linhas = 4'b1110), Codigo = 0, Valido = 0, Pressionada = 0, prescaler and counters = 0, synchronizer flops = 4'b1111.
REQ-024 Reset asserted mid-press SHALL abort without a Valido pulse; after release a still-held key SHALL be re-detected as a new press.

Configuration
REQ-025 With AUTO_REPEAT_EN defined, PRESSIONADA SHALL pulse Valido (same Codigo) every REPEAT_SAMPLES samples while held; without it, exactly one Valido per press and REPEAT_SAMPLES is unused.

Structure
REQ-026 SHALL place the FSM state enum and key-code width constant in shared package teclado_pkg.
REQ-027 SHALL instantiate the synchronizer as sub-module sincronizador_2ff (4 bits, reset value all ones).

Verification (DIV_SCAN=4, DEBOUNCE=3)
REQ-028 Reset then idle 100 cycles -> Linhas cycles 1110,1101,1011,0111, Valido never high, Codigo = 0.
REQ-029 Hold key row 2/col 1 (Colunas[1] low while Linhas[2] low) -> exactly one Valido pulse, Codigo = 9, Pressionada = 1 within 31 cycles.
REQ-030 Key row 0/col 0 released after 2 samples in CONFIRMA -> no Valido, scan resumes at row 1.
REQ-031 Key held, then 1-sample release glitch -> no second Valido, Pressionada stays 1; full release -> Pressionada = 0 after 3 high samples.
REQ-032 Keys (1,0) and (1,3) pressed together -> Codigo = 4 only.
REQ-033 With AUTO_REPEAT_EN and REPEAT_SAMPLES=8, key row 3/col 3 held 200 cycles -> Valido repeats every 32 cycles, Codigo = 15; Reset mid-hold clears all outputs immediately.
